sys_mem_responder: RTL and testbench
====================================

// Module: sys_mem_responder
// PURPOSE
//  System-bus target answering transactions initiated by the cache controller.
//  - Holds a synchronous word memory.
//  - Accepts one strobed read/write at a time.
//  - Inserts a fixed, parameterised number of wait states, then returns SysReady.
//  - Returns read data with an output enable.
//  - Sits on the system side of the cache, in place of main memory.
// PARAMETERS
//  DW           32    data width, bits
//  AW           10    word-address width, bits
//  DEPTH        1024  memory words implemented (must be <= 2**AW)
//  WAIT_STATES  3     cycles spent in WAIT between strobe and response (0..15)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-high
//  SysStrobe   in   1   one-cycle request pulse from initiator
//  SysRW       in   1   1 = read, 0 = write; sampled with SysStrobe
//  SysAddr     in   AW  word address; sampled with SysStrobe
//  SysWData    in   DW  write data; sampled with SysStrobe
//  SysRData    out  DW  read data; valid only while SysRDataOE = 1
//  SysRDataOE  out  1   responder driving SysRData
//  SysReady    out  1   one-cycle completion pulse
//  SysBusy     out  1   transaction in progress (state != IDLE)
// BEHAVIOUR
//  - Reset: clk; reset is synchronous, active-high.
//    - Forces state IDLE and the wait counter to 0.
//    - SysReady, SysRDataOE and SysBusy are 0; SysRData is 0.
//    - Memory contents are not reset.
//  - States:
//    - IDLE: on SysStrobe, latch RW, addr and wdata.
//      - Go to WAIT, loading cnt = WAIT_STATES-1, if WAIT_STATES > 0.
//      - Otherwise go straight to RESP.
//    - WAIT: cnt decrements each cycle; when cnt == 0, go to RESP.
//    - RESP: for one cycle, SysReady = 1.
//      - Read: SysRDataOE = 1 and SysRData = mem[addr].
//      - Write: mem[addr] <= latched wdata at the end of this cycle.
//      - Next state is IDLE.
//  - Latency: strobe sampled at edge N gives SysReady high in cycle N+1+WAIT_STATES.
//    - The initiator's wait-state count must be configured to match.
//  - Read data: registered from the memory on entry to RESP.
//    - SysRData returns to 0 whenever SysRDataOE = 0.
//  - Outputs are registered, Moore style; no output depends combinationally on
//    inputs.
//  - SysStrobe outside IDLE: ignored, no queuing; the initiator must not overlap
//    requests.
//  - Strobe in the RESP cycle is also ignored; IDLE must be re-entered first, so
//    back-to-back requests are spaced at least WAIT_STATES+2 cycles.
//  - SysAddr >= DEPTH (feature off):
//    - Writes are dropped.
//    - Reads return 0.
//    - SysReady is still given.
//  - Reset mid-operation: the transaction is abandoned and no memory write occurs.
//    - A write latched but not yet in RESP is lost.
//    - SysReady is not pulsed.
//  - Read-after-write to the same address in consecutive transactions returns the
//    new data.
// CONFIGURATION
//  - SYS_MEM_ERR_EN defined:
//    - Adds output port SysErr (1 bit, reset 0).
//    - SysErr pulses with SysReady in RESP when the latched addr >= DEPTH.
//    - The error read returns SysRData = {DW{1'b1}} with SysRDataOE = 1.
//    - The write is dropped.
//  - SYS_MEM_ERR_EN undefined: no SysErr port; out-of-range handling as in
//    BEHAVIOUR.
// TESTING
//  1. Reset held 2 cycles, then released.
//     -> SysReady = SysRDataOE = SysBusy = 0 and SysRData = 0 on every cycle.
//  2. Write at addr 0x005 with data 0xDEADBEEF, WAIT_STATES = 3, strobe at edge 10.
//     -> SysReady only in cycle 14.
//     -> Then read addr 0x005 returns 0xDEADBEEF with SysRDataOE = 1.
//  3. WAIT_STATES = 0: read strobe at edge N.
//     -> SysReady and data in cycle N+1.
//     -> Second strobe at N+1 ignored; strobe at N+2 accepted.
//  4. Write addr 0x00A with data 0x1234 issued; reset pulsed during WAIT.
//     -> No SysReady.
//     -> Subsequent read of 0x00A returns the prior value 0x0000_0000 preloaded.
//  5. Extra strobes while SysBusy = 1.
//     -> Ignored: exactly one SysReady per accepted request; mem unaffected.
//  6. SYS_MEM_ERR_EN, DEPTH = 512: read addr 0x200.
//     -> SysErr = 1 with SysReady and SysRData = 0xFFFFFFFF.
//     -> Write to 0x200 leaves mem unchanged.

Source files
------------

// File: rtl/sys_mem_responder.sv
// sys_mem_responder
//   System-bus target that stands in for main memory on the system side of
//   the cache. It accepts one strobed read or write at a time, spends a fixed
//   number of wait states, then pulses SysReady for one cycle. Reads return
//   data with SysRDataOE. All outputs are registered (Moore).
//
// Parameters
//   DW           data width, bits
//   AW           word-address width, bits
//   DEPTH        words implemented (DEPTH <= 2**AW)
//   WAIT_STATES  cycles spent in WAIT between strobe and response (0..15)
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   SysStrobe   one-cycle request pulse, honoured only in IDLE
//   SysRW       1 = read, 0 = write; sampled with SysStrobe
//   SysAddr     word address; sampled with SysStrobe
//   SysWData    write data; sampled with SysStrobe
//   SysRData    read data; 0 whenever SysRDataOE = 0
//   SysRDataOE  responder driving SysRData
//   SysReady    one-cycle completion pulse
//   SysBusy     transaction in progress
//   SysErr      (SYS_MEM_ERR_EN only) out-of-range access, pulses with SysReady
//
// Build option
//   SYS_MEM_ERR_EN : adds SysErr; an out-of-range read returns all ones.
//                    Without it, out-of-range reads return 0 and writes drop.

module sys_mem_responder #(
   parameter int unsigned DW          = 32,
   parameter int unsigned AW          = 10,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          SysStrobe,
   input  logic          SysRW,
   input  logic [AW-1:0] SysAddr,
   input  logic [DW-1:0] SysWData,
   output logic [DW-1:0] SysRData,
   output logic          SysRDataOE,
   output logic          SysReady,
   output logic          SysBusy
`ifdef SYS_MEM_ERR_EN
   ,
   output logic          SysErr
`endif
);

   localparam int unsigned CW = 4;
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CNT_INIT =
      (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;
   localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic            rw_q,    rw_d;
   logic [AW-1:0]   addr_q,  addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            oe_q,    oe_d;
   logic            ready_q, ready_d;
   logic            busy_q,  busy_d;
`ifdef SYS_MEM_ERR_EN
   logic            err_q,   err_d;
`endif

   logic            in_range_d;
   logic            in_range_q;
   logic            mem_we;

   logic [DW-1:0]   mem [DEPTH];

   // Next-state, request latch and wait counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (SysStrobe) begin
               rw_d    = SysRW;
               addr_d  = SysAddr;
               wdata_d = SysWData;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            // Strobes seen here are dropped; IDLE must be re-entered first.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output next values, evaluated against the state being entered so that
   // the registered outputs line up with the RESP cycle itself.
   always_comb begin
      in_range_d = ({1'b0, addr_d} < DEPTH_LIM);
      ready_d    = (state_d == ST_RESP);
      busy_d     = (state_d != ST_IDLE);
      oe_d       = ready_d & rw_d;
      rdata_d    = '0;
      if (oe_d) begin
         if (in_range_d) begin
            rdata_d = mem[IW'(addr_d)];
         end else begin
`ifdef SYS_MEM_ERR_EN
            rdata_d = '1;
`else
            rdata_d = '0;
`endif
         end
      end
`ifdef SYS_MEM_ERR_EN
      err_d = ready_d & ~in_range_d;
`endif
   end

   // Write commits at the end of RESP; a reset in that cycle cancels it.
   always_comb begin
      in_range_q = ({1'b0, addr_q} < DEPTH_LIM);
      mem_we     = ~reset & (state_q == ST_RESP) & ~rw_q & in_range_q;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         oe_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SYS_MEM_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         oe_q    <= oe_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
`ifdef SYS_MEM_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   // Word memory; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[IW'(addr_q)] <= wdata_q;
      end
   end

   assign SysRData   = rdata_q;
   assign SysRDataOE = oe_q;
   assign SysReady   = ready_q;
   assign SysBusy    = busy_q;
`ifdef SYS_MEM_ERR_EN
   assign SysErr     = err_q;
`endif

endmodule

// File: tb/tb_sys_mem_responder.sv
// tb_sys_mem_responder
//   Two responders share one clock: dut 0 has WAIT_STATES = 3 and DEPTH = 512,
//   dut 1 has WAIT_STATES = 0 and DEPTH = 1024. Directed transactions push
//   their expected response (cycle, read flag, data, error) into a per-dut
//   queue; a monitor on the falling edge pops and compares on SysReady and
//   checks idle outputs and SysBusy on every other cycle.

module tb_sys_mem_responder;

   typedef struct {
      int          cyc;
      logic        rd;
      logic [31:0] data;
      logic        err;
   } exp_t;

`ifdef SYS_MEM_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic        clk;
   logic        rst   [2];
   logic        strb  [2];
   logic        rw    [2];
   logic [9:0]  addr  [2];
   logic [31:0] wd    [2];
   logic [31:0] rdata [2];
   logic        oe    [2];
   logic        rdy   [2];
   logic        busy  [2];
   logic        err_o [2];
   bit          busy_ign [2];

   exp_t q0[$];
   exp_t q1[$];

   int cyc;
   int nvec;
   int nfail;

   sys_mem_responder #(.DW(32), .AW(10), .DEPTH(512), .WAIT_STATES(3)) u_dut0 (
      .clk        (clk),
      .reset      (rst[0]),
      .SysStrobe  (strb[0]),
      .SysRW      (rw[0]),
      .SysAddr    (addr[0]),
      .SysWData   (wd[0]),
      .SysRData   (rdata[0]),
      .SysRDataOE (oe[0]),
      .SysReady   (rdy[0]),
      .SysBusy    (busy[0])
`ifdef SYS_MEM_ERR_EN
      ,
      .SysErr     (err_o[0])
`endif
   );

   sys_mem_responder #(.DW(32), .AW(10), .DEPTH(1024), .WAIT_STATES(0)) u_dut1 (
      .clk        (clk),
      .reset      (rst[1]),
      .SysStrobe  (strb[1]),
      .SysRW      (rw[1]),
      .SysAddr    (addr[1]),
      .SysWData   (wd[1]),
      .SysRData   (rdata[1]),
      .SysRDataOE (oe[1]),
      .SysReady   (rdy[1]),
      .SysBusy    (busy[1])
`ifdef SYS_MEM_ERR_EN
      ,
      .SysErr     (err_o[1])
`endif
   );

`ifndef SYS_MEM_ERR_EN
   initial begin
      err_o[0] = 1'b0;
      err_o[1] = 1'b0;
   end
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ws_of(input int d);
      return (d == 0) ? 3 : 0;
   endfunction

   task automatic cmp(input string name, input int d, input logic [31:0] act,
                      input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, d, cyc, act, req);
      end
   endtask

   // One monitor step for dut d given the head of its queue
   task automatic step(input int d, input bit have, input exp_t e, output bit pop);
      pop = 1'b0;
      if (have && e.cyc < cyc) begin
         nvec++;
         nfail++;
         pop = 1'b1;
         $display("FAIL missing_ready dut%0d cyc %0d: got none want cyc %0d", d, cyc, e.cyc);
      end else if (rdy[d] === 1'b1) begin
         if (!have || e.cyc != cyc) begin
            nvec++;
            nfail++;
            $display("FAIL unexpected_ready dut%0d cyc %0d: got ready want cyc %0d",
                     d, cyc, have ? e.cyc : -1);
         end else begin
            pop = 1'b1;
            cmp("resp_oe", d, 32'(oe[d]), 32'(e.rd));
            cmp("resp_data", d, rdata[d], e.data);
            if (ERR) cmp("resp_err", d, 32'(err_o[d]), 32'(e.err));
         end
      end else begin
         cmp("idle_ready", d, 32'(rdy[d]), 32'd0);
         cmp("idle_oe", d, 32'(oe[d]), 32'd0);
         cmp("idle_data", d, rdata[d], 32'd0);
         if (ERR) cmp("idle_err", d, 32'(err_o[d]), 32'd0);
      end
      if (!busy_ign[d]) begin
         cmp("busy", d, 32'(busy[d]),
             32'(have && (cyc >= e.cyc - ws_of(d)) && (cyc <= e.cyc)));
      end
   endtask

   // Scoreboard monitor, sampling away from the rising edge
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      bit   pop;
      if (cyc > 0) begin
         have = (q0.size() > 0);
         e    = have ? q0[0] : '{cyc: 0, rd: 1'b0, data: 32'd0, err: 1'b0};
         step(0, have, e, pop);
         if (pop) void'(q0.pop_front());
         have = (q1.size() > 0);
         e    = have ? q1[0] : '{cyc: 0, rd: 1'b0, data: 32'd0, err: 1'b0};
         step(1, have, e, pop);
         if (pop) void'(q1.pop_front());
      end
   end

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Single transaction, called at a falling edge; returns after completion
   task automatic xact(input int d, input logic r, input logic [9:0] a,
                       input logic [31:0] w, input logic [31:0] ed, input logic ee);
      exp_t e;
      e.cyc  = cyc + 1 + ws_of(d);
      e.rd   = r;
      e.data = r ? ed : 32'd0;
      e.err  = ee;
      push(d, e);
      strb[d] = 1'b1;
      rw[d]   = r;
      addr[d] = a;
      wd[d]   = w;
      @(negedge clk);
      strb[d] = 1'b0;
      repeat (ws_of(d) + 2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc %0d: got timeout want finish", cyc);
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   n;
      nvec  = 0;
      nfail = 0;
      for (int d = 0; d < 2; d++) begin
         rst[d]      = 1'b1;
         strb[d]     = 1'b0;
         rw[d]       = 1'b0;
         addr[d]     = '0;
         wd[d]       = '0;
         busy_ign[d] = 1'b0;
      end

      // Reset held for two edges; monitor checks idle outputs throughout
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // Write 0x005 sampled at edge 10, SysReady in the cycle after edge 13
      while (cyc < 9) @(negedge clk);
      xact(0, 1'b0, 10'h005, 32'hDEADBEEF, 32'h0, 1'b0);
      xact(0, 1'b1, 10'h005, 32'h0, 32'hDEADBEEF, 1'b0);

      // Zero wait states: preload, then a strobe held for three edges
      xact(1, 1'b0, 10'h030, 32'h11111111, 32'h0, 1'b0);
      xact(1, 1'b0, 10'h031, 32'h22222222, 32'h0, 1'b0);
      xact(1, 1'b0, 10'h032, 32'h33333333, 32'h0, 1'b0);
      xact(1, 1'b1, 10'h031, 32'h0, 32'h22222222, 1'b0);
      e = '{cyc: cyc + 1, rd: 1'b1, data: 32'h11111111, err: 1'b0};
      push(1, e);
      e = '{cyc: cyc + 3, rd: 1'b1, data: 32'h33333333, err: 1'b0};
      push(1, e);
      strb[1] = 1'b1;
      rw[1]   = 1'b1;
      addr[1] = 10'h030;
      @(negedge clk);
      addr[1] = 10'h031;
      @(negedge clk);
      addr[1] = 10'h032;
      @(negedge clk);
      strb[1] = 1'b0;
      repeat (3) @(negedge clk);

      // Reset during WAIT abandons the write to 0x00A
      xact(0, 1'b0, 10'h00A, 32'h00000000, 32'h0, 1'b0);
      busy_ign[0] = 1'b1;
      strb[0] = 1'b1;
      rw[0]   = 1'b0;
      addr[0] = 10'h00A;
      wd[0]   = 32'h00001234;
      @(negedge clk);
      strb[0] = 1'b0;
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      @(negedge clk);
      busy_ign[0] = 1'b0;
      repeat (5) @(negedge clk);
      xact(0, 1'b1, 10'h00A, 32'h0, 32'h00000000, 1'b0);

      // Extra strobes while busy are ignored
      xact(0, 1'b0, 10'h021, 32'hA5A5A5A5, 32'h0, 1'b0);
      e = '{cyc: cyc + 4, rd: 1'b0, data: 32'h0, err: 1'b0};
      push(0, e);
      strb[0] = 1'b1;
      rw[0]   = 1'b0;
      addr[0] = 10'h020;
      wd[0]   = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rw[0]   = 1'(i % 2);
         addr[0] = 10'h021;
         wd[0]   = 32'hBAD00000 + 32'(i);
      end
      @(negedge clk);
      strb[0] = 1'b0;
      repeat (4) @(negedge clk);
      xact(0, 1'b1, 10'h020, 32'h0, 32'hCAFEF00D, 1'b0);
      xact(0, 1'b1, 10'h021, 32'h0, 32'hA5A5A5A5, 1'b0);

      // Address range boundary on the 512-word responder
      xact(0, 1'b0, 10'h000, 32'h0BADCAFE, 32'h0, 1'b0);
      xact(0, 1'b0, 10'h1FF, 32'h76543210, 32'h0, 1'b0);
      xact(0, 1'b1, 10'h200, 32'h0, ERR ? 32'hFFFFFFFF : 32'h0, ERR);
      xact(0, 1'b0, 10'h200, 32'h5555AAAA, 32'h0, ERR);
      xact(0, 1'b1, 10'h000, 32'h0, 32'h0BADCAFE, 1'b0);
      xact(0, 1'b1, 10'h1FF, 32'h0, 32'h76543210, 1'b0);

      // Drain both scoreboards within a bounded number of cycles
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      nvec++;
      if (q0.size() > 0 || q1.size() > 0) begin
         nfail++;
         $display("FAIL drain cyc %0d: got %0d pending want 0", cyc, q0.size() + q1.size());
      end
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
